// File: rtl/bgd_pkg.sv
// Shared widths, bus payload types and saturating arithmetic helpers for the BGD
// dot-product accumulator.
package bgd_pkg;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned PROD_W  = 14;
  localparam int unsigned ACC_W   = 20;
  localparam int unsigned OUT_W   = 14;

  // {valid,last} pair carried alongside the multiplier pipeline
  typedef struct packed {
    logic valid;
    logic last;
  } vl_t;

  localparam int unsigned VL_W = $bits(vl_t);

  typedef struct packed {
    logic                    sat;
    logic signed [ACC_W-1:0] val;
  } acc_res_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] val;
  } out_res_t;

  // Signed add at ACC_W+1 bits, clamped back into the ACC_W range.
  function automatic acc_res_t sat_add(input logic signed [ACC_W-1:0] a,
                                       input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    acc_res_t              r;
    s     = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.sat = s[ACC_W] ^ s[ACC_W-1];
    if (!r.sat) begin
      r.val = s[ACC_W-1:0];
    end else if (s[ACC_W]) begin
      r.val = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      r.val = {1'b0, {(ACC_W-1){1'b1}}};
    end
    return r;
  endfunction

  // ReLU followed by clamp to the largest positive OUT_W-bit signed value.
  function automatic out_res_t relu_clamp(input logic signed [ACC_W-1:0] a);
    out_res_t r;
    r.sat = 1'b0;
    r.val = '0;
    if (!a[ACC_W-1]) begin
      if (|a[ACC_W-2:OUT_W-1]) begin
        r.sat = 1'b1;
        r.val = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        r.val = a[OUT_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bgd_valid_delay.sv
// Enabled shift register that tracks operand qualifiers through the multiplier latency.
module bgd_valid_delay #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sr_q[i] <= '0;
      end
    end else if (en_i) begin
      sr_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/bgd_dot_accum_relu.sv
// Accumulates signed multiplier products per vector, applies ReLU and saturation, and
// presents each result through a one-entry valid/ready buffer that stalls the multiplier.
module bgd_dot_accum_relu
  import bgd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mul_ce,
  input  logic [PROD_W-1:0] mul_p,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sat
);

  logic                    stall_c;
  logic                    ce_c;
  vl_t                     dl_in_c;
  vl_t                     tap_c;
  logic signed [ACC_W-1:0] prod_ext_c;
  logic signed [ACC_W-1:0] base_c;
  acc_res_t                sum_c;
  out_res_t                res_c;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic                    sticky_q, sticky_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  // A held result freezes the multiplier and the qualifier pipeline together
  assign stall_c  = out_valid_q & ~out_ready;
  assign ce_c     = ~stall_c;
  assign mul_ce   = ce_c;
  assign in_ready = ce_c;

  assign dl_in_c.valid = in_valid;
  assign dl_in_c.last  = in_valid & in_last;

  bgd_valid_delay #(
    .DEPTH (MUL_LAT),
    .WIDTH (VL_W)
  ) u_valid_delay (
    .clk   (clk),
    .reset (reset),
    .en_i  (ce_c),
    .d_i   (dl_in_c),
    .q_o   (tap_c)
  );

  assign prod_ext_c = ACC_W'(signed'(mul_p));

  // Accumulate, finalize on last term, and manage the output buffer
  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    sticky_d    = sticky_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;

    base_c = first_q ? '0 : acc_q;
    sum_c  = sat_add(base_c, prod_ext_c);
    res_c  = relu_clamp(sum_c.val);

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (ce_c && tap_c.valid) begin
      if (tap_c.last) begin
        out_valid_d = 1'b1;
        out_data_d  = res_c.val;
        out_sat_d   = sticky_q | sum_c.sat | res_c.sat;
        acc_d       = '0;
        sticky_d    = 1'b0;
        first_d     = 1'b1;
      end else begin
        acc_d    = sum_c.val;
        sticky_d = sticky_q | sum_c.sat;
        first_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      sticky_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      sticky_q    <= sticky_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_bgd_dot_accum_relu.sv
// Scoreboard bench for bgd_dot_accum_relu with a behavioural 3-stage multiplier in front.
module tb_bgd_dot_accum_relu;

  localparam int unsigned PW = 14;
  localparam int unsigned OW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          mul_ce;
  logic [PW-1:0] mul_p;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sat;

  logic signed [PW-1:0] op_a;
  logic signed [PW-1:0] op_b;
  logic signed [PW-1:0] mst [3];

  int   n_checks = 0;
  int   n_pass   = 0;
  logic rdy_random = 1'b0;
  logic rdy_hold   = 1'b0;
  int   wcnt;

  typedef struct {
    string name;
    int    data;
    int    sat;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  bgd_dot_accum_relu dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mul_ce    (mul_ce),
    .mul_p     (mul_p),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat)
  );

  // 14s x 14s multiplier, truncated product, 3 ce-enabled stages
  always @(posedge clk) begin
    if (mul_ce) begin
      mst[0] <= op_a * op_b;
      mst[1] <= mst[0];
      mst[2] <= mst[1];
    end
  end
  assign mul_p = mst[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input string name, input int d, input int s);
    exp_t e;
    e.name = name;
    e.data = d;
    e.sat  = s;
    exp_q.push_back(e);
  endtask

  // Present one operand pair and hold it until accepted
  task automatic send(input int a, input int b, input logic last);
    int   cnt;
    logic ok;
    cnt = 0;
    ok  = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_last  = last;
    op_a     = PW'(a);
    op_b     = PW'(b);
    forever begin
      #4;
      ok = in_ready;
      @(posedge clk);
      cnt++;
      if (ok || cnt >= 2000) break;
      @(negedge clk);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, expected 1", cnt);
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 5000) begin
      @(posedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Downstream ready generator
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = rdy_random ? 1'($urandom_range(0, 1)) : ~rdy_hold;
    end
  end

  // Monitor: compare every transfer against the head of the scoreboard
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #4;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_result: got data %0d sat %0d, expected no result", out_data, out_sat);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_data"}, int'(out_data), e.data);
          check({e.name, "_sat"}, int'(out_sat), e.sat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    op_a     = '0;
    op_b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_mul_ce", int'(mul_ce), 1);
    @(negedge clk);
    reset = 1'b0;

    // 12 - 10 + 7 + 1 = 10
    push_exp("t1", 10, 0);
    send(3, 4, 1'b0);
    send(-2, 5, 1'b0);
    send(7, 1, 1'b0);
    send(1, 1, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_latency_edge%0d", i), int'(out_valid), (i == 3) ? 1 : 0);
    end
    drain();

    // -25 + 6 - 6 = -25 -> ReLU 0
    push_exp("t2_relu", 0, 0);
    send(-5, 5, 1'b0);
    send(2, 3, 1'b0);
    send(-3, 2, 1'b1);
    push_exp("max_exact", 8191, 0);
    send(8191, 1, 1'b1);
    push_exp("out_clamp", 8191, 1);
    send(90, 90, 1'b0);
    send(90, 90, 1'b1);
    drain();

    // 70 x 8191 exceeds 2^19-1 at the 65th term
    push_exp("acc_pos_sat", 8191, 1);
    for (int i = 0; i < 70; i++) send(8191, 1, (i == 69));
    push_exp("after_sat", 6, 0);
    send(2, 3, 1'b1);
    push_exp("acc_neg_sat", 0, 1);
    for (int i = 0; i < 70; i++) send(-8192, 1, (i == 69));
    drain();

    // Back-to-back vectors with a 5-cycle downstream hold
    rdy_hold = 1'b1;
    push_exp("t4_a", 41, 0);
    push_exp("t4_b", 28, 0);
    fork
      begin
        send(4, 4, 1'b0);
        send(5, 5, 1'b1);
        send(-3, 3, 1'b0);
        send(6, 6, 1'b0);
        send(1, 1, 1'b1);
      end
      begin
        wcnt = 0;
        @(negedge clk);
        #4;
        while (!out_valid && wcnt < 100) begin
          @(negedge clk);
          #4;
          wcnt++;
        end
        for (int i = 0; i < 5; i++) begin
          check("t4_in_ready_hold", int'(in_ready), 0);
          check("t4_mul_ce_hold", int'(mul_ce), 0);
          check("t4_data_hold", int'(out_data), 41);
          if (i < 4) begin
            @(negedge clk);
            #4;
          end
        end
        rdy_hold = 1'b0;
      end
    join
    drain();

    // Random bubbles and backpressure against an integer reference model
    rdy_random = 1'b1;
    for (int v = 0; v < 300; v++) begin
      int ta[6];
      int tb[6];
      int len;
      int acc;
      int sat;
      int ed;
      logic signed [PW-1:0] pt;
      len = int'($urandom_range(1, 6));
      acc = 0;
      sat = 0;
      for (int t = 0; t < len; t++) begin
        ta[t] = int'($urandom_range(0, 400)) - 200;
        tb[t] = int'($urandom_range(0, 400)) - 200;
        pt    = PW'(ta[t] * tb[t]);
        acc   = acc + int'(pt);
        if (acc > 524287) begin
          acc = 524287;
          sat = 1;
        end else if (acc < -524288) begin
          acc = -524288;
          sat = 1;
        end
      end
      if (acc < 0) ed = 0;
      else if (acc > 8191) begin
        ed  = 8191;
        sat = 1;
      end else ed = acc;
      push_exp($sformatf("rnd%0d", v), ed, sat);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(0, 3) == 0) repeat (int'($urandom_range(1, 2))) @(posedge clk);
        send(ta[t], tb[t], (t == len - 1));
      end
    end
    drain();
    rdy_random = 1'b0;

    // Reset in the middle of a vector discards the partial sum
    send(1, 2, 1'b0);
    send(3, 4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_out_sat", int'(out_sat), 0);
    @(negedge clk);
    reset = 1'b0;
    push_exp("t6_single", 25, 0);
    send(5, 5, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
